// File: rtl/imem_boot_loader_if.sv
// Loader byte stream, instruction-memory write port and CPU release signals.
// The loader itself is the slave side; the byte source / memory / CPU side is the master.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
           cpu_rst, load_done, load_err, words_loaded
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           cpu_rst, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: zero-fills instruction memory, then takes a 16-bit word count
// and big-endian 32-bit words from a byte stream, writes them from address 0
// upward and finally releases the CPU from reset.
module imem_boot_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus
);

  // Counter wide enough to hold DEPTH itself (clear index, word count).
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_clr_cnt;
  logic [15:0]         r_n;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;
  logic [CNT_W-1:0]    r_words;

  state_t              w_state_next;
  logic [CNT_W-1:0]    w_clr_cnt_next;
  logic [15:0]         w_n_next;
  logic [1:0]          w_byte_cnt_next;
  logic [23:0]         w_shift_next;
  logic                w_we_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [31:0]         w_wdata_next;
  logic                w_cpu_rst_next;
  logic                w_done_next;
  logic                w_err_next;
  logic [CNT_W-1:0]    w_words_next;
  logic [15:0]         w_hdr_n;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_last_word;

  // Byte acceptance is only possible while reading the header or the image.
  assign w_in_ready  = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA);
  assign w_accept    = bus.in_valid && w_in_ready;
  // True when the word being completed is the last one of the image.
  assign w_last_word = ((17'(r_words) + 17'd1) == {1'b0, r_n});

  // State and output registers; reset re-holds the CPU and restarts at CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_CLEAR;
      r_clr_cnt  <= '0;
      r_n        <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_n        <= w_n_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_shift    <= w_shift_next;
      r_we       <= w_we_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_cpu_rst  <= w_cpu_rst_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_words    <= w_words_next;
    end
  end

  // Next-state and next-output decode; the write strobe is a single-cycle pulse.
  always_comb begin
    w_state_next    = r_state;
    w_clr_cnt_next  = r_clr_cnt;
    w_n_next        = r_n;
    w_byte_cnt_next = r_byte_cnt;
    w_shift_next    = r_shift;
    w_we_next       = 1'b0;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_cpu_rst_next  = r_cpu_rst;
    w_done_next     = r_done;
    w_err_next      = r_err;
    w_words_next    = r_words;
    w_hdr_n         = {r_n[15:8], bus.in_data};

    case (r_state)
      S_CLEAR: begin
        // One zero write per cycle; the edge after the last write leaves CLEAR.
        if (r_clr_cnt < CNT_W'(DEPTH)) begin
          w_we_next      = 1'b1;
          w_addr_next    = r_clr_cnt[ADDR_W-1:0];
          w_wdata_next   = '0;
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end else begin
          w_state_next   = S_HDR_HI;
        end
      end

      S_HDR_HI: begin
        if (w_accept) begin
          w_n_next[15:8] = bus.in_data;
          w_state_next   = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (w_accept) begin
          w_n_next        = w_hdr_n;
          w_byte_cnt_next = '0;
          if (w_hdr_n == 16'd0) begin
            w_state_next = S_DONE;
          end else if (17'(w_hdr_n) > 17'(DEPTH)) begin
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        // Bytes shift in MSB first; the 4th byte completes and writes the word.
        if (w_accept) begin
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          w_shift_next    = {r_shift[15:0], bus.in_data};
          if (r_byte_cnt == 2'd3) begin
            w_we_next    = 1'b1;
            w_addr_next  = r_words[ADDR_W-1:0];
            w_wdata_next = {r_shift, bus.in_data};
            w_words_next = r_words + 1'b1;
            if (w_last_word) begin
              w_state_next = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        w_done_next    = 1'b1;
        w_cpu_rst_next = 1'b1;
      end

      S_ERR: begin
        w_err_next = 1'b1;
      end

      default: begin
        w_state_next = S_CLEAR;
      end
    endcase
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_rst      = r_cpu_rst;
  assign bus.load_done    = r_done;
  assign bus.load_err     = r_err;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of load scenarios plus a reset-mid-load
// sequence; data writes are matched against a scoreboard of expected writes.
module tb_imem_boot_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef struct {
    logic [15:0] n;          // header word count
    int          gap_max;    // max idle cycles before each byte
    bit          preload;    // poison addr 200 before reset release
    bit          exp_err;    // expected load_err (else load_done)
    logic [8:0]  exp_words;  // expected words_loaded at the end
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_bad;
  wr_t         sb[$];
  bit          sb_on;
  logic [31:0] mem [DEPTH];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] img(input int i);
    case (i)
      0:       img = 32'h20080005;
      1:       img = 32'h2009000A;
      2:       img = 32'h01095020;
      default: img = {16'hC0DE, 16'(i)};
    endcase
  endfunction

  function automatic logic [63:0] all_outputs();
    all_outputs = {15'd0, bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                   bus.cpu_rst, bus.load_done, bus.load_err, bus.words_loaded};
  endfunction

  // One clock: sample 1 time unit after the edge, update memory model, score writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.imem_we === 1'b1) begin
      mem[bus.imem_addr] = bus.imem_wdata;
      if (sb_on) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {24'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
          check("wr_data", 64'(bus.imem_wdata), 64'(e.data));
        end
      end
    end
  endtask

  // Reset, optional poisoning, release, then check the full clear sweep timing.
  task automatic start_case(input bit preload);
    int clr_ok;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    sb_on        = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    if (preload) mem[200] = 32'hFFFFFFFF;
    tick();
    rst = 1'b1;
    clr_ok = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (bus.imem_we === 1'b1 && bus.imem_addr == 8'(k - 1) && bus.imem_wdata == 32'd0 &&
          bus.in_ready === 1'b0)
        clr_ok++;
    end
    check("clear_sweep", 64'(clr_ok), 64'(DEPTH));
    tick();
    check("clear_end_we_ready", {62'd0, bus.imem_we, bus.in_ready}, 64'b01);
    sb_on = 1'b1;
  endtask

  // Offer one byte after a random gap; check the write pulse appears exactly
  // on the cycle after the 4th byte of a word is accepted and never otherwise.
  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit wr_exp);
    int  gap;
    int  waited;
    bit  rdy;
    gap = $urandom_range(gap_max, 0);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      tick();
      check("we_in_gap", 64'(bus.imem_we), 64'd0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waited = 0;
    do begin
      rdy = bus.in_ready;
      tick();
      waited++;
    end while (!rdy && waited < 50);
    if (!rdy) check("accept_timeout", 64'(waited), 64'd0);
    check("write_latency", 64'(bus.imem_we), 64'(wr_exp));
  endtask

  // Header, nwords complete words (scoreboarded), then tail partial-word bytes.
  task automatic load_image(input logic [15:0] n, input int gap_max, input int nwords, input int tail);
    logic [31:0] w;
    send_byte(n[15:8], gap_max, 1'b0);
    send_byte(n[7:0], gap_max, 1'b0);
    for (int i = 0; i < nwords; i++) begin
      w = img(i);
      sb.push_back('{addr: 8'(i), data: w});
      send_byte(w[31:24], gap_max, 1'b0);
      send_byte(w[23:16], gap_max, 1'b0);
      send_byte(w[15:8],  gap_max, 1'b0);
      send_byte(w[7:0],   gap_max, 1'b1);
    end
    w = img(nwords);
    for (int t = 0; t < tail; t++) begin
      send_byte(w[31 - 8*t -: 8], gap_max, 1'b0);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nw;
    int bad;
    int hold_bad;
    nw = v.exp_err ? 0 : int'(v.n);
    start_case(v.preload);
    load_image(v.n, v.gap_max, nw, 0);
    bus.in_valid = 1'b0;
    check("release_not_early", {62'd0, bus.cpu_rst, bus.in_ready}, 64'd0);
    tick();
    if (v.exp_err) begin
      check("err_flags", {61'd0, bus.cpu_rst, bus.load_done, bus.load_err}, 64'b001);
      hold_bad = 0;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
        bus.in_data = 8'($urandom);
        tick();
        if (bus.cpu_rst !== 1'b0 || bus.in_ready !== 1'b0 || bus.load_err !== 1'b1) hold_bad++;
      end
      bus.in_valid = 1'b0;
      check("err_hold", 64'(hold_bad), 64'd0);
    end else begin
      check("done_flags", {61'd0, bus.cpu_rst, bus.load_done, bus.load_err}, 64'b110);
      check("done_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
        bus.in_data = 8'($urandom);
        tick();
      end
      bus.in_valid = 1'b0;
      check("done_hold", {61'd0, bus.cpu_rst, bus.load_done, bus.load_err}, 64'b110);
    end
    check("words_loaded", 64'(bus.words_loaded), 64'(v.exp_words));
    check("sb_drained", 64'(sb.size()), 64'd0);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== ((a < nw) ? img(a) : 32'd0)) bad++;
    end
    check("mem_image", 64'(bad), 64'd0);
    if (v.preload) check("addr200_cleared", 64'(mem[200]), 64'd0);
    $display("case %0d: N=%0d gap<=%0d err=%0b words=%0d done=%0b cpu_rst=%0b",
             idx, v.n, v.gap_max, bus.load_err, bus.words_loaded, bus.load_done, bus.cpu_rst);
  endtask

  vec_t vecs [8];

  initial begin
    n_vec        = 0;
    n_bad        = 0;
    sb_on        = 1'b0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int a = 0; a < DEPTH; a++) mem[a] = 32'hDEAD0000 | 32'(a);

    vecs[0] = '{n: 16'd3,     gap_max: 0, preload: 1'b0, exp_err: 1'b0, exp_words: 9'd3};
    vecs[1] = '{n: 16'd2,     gap_max: 0, preload: 1'b1, exp_err: 1'b0, exp_words: 9'd2};
    vecs[2] = '{n: 16'd3,     gap_max: 5, preload: 1'b0, exp_err: 1'b0, exp_words: 9'd3};
    vecs[3] = '{n: 16'd0,     gap_max: 0, preload: 1'b0, exp_err: 1'b0, exp_words: 9'd0};
    vecs[4] = '{n: 16'd257,   gap_max: 0, preload: 1'b0, exp_err: 1'b1, exp_words: 9'd0};
    vecs[5] = '{n: 16'd1,     gap_max: 3, preload: 1'b0, exp_err: 1'b0, exp_words: 9'd1};
    vecs[6] = '{n: 16'd256,   gap_max: 0, preload: 1'b0, exp_err: 1'b0, exp_words: 9'd256};
    vecs[7] = '{n: 16'hFFFF,  gap_max: 1, preload: 1'b0, exp_err: 1'b1, exp_words: 9'd0};

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset mid-load: header, word 0, two bytes of word 1, then async reset mid-cycle.
    start_case(1'b0);
    load_image(16'd3, 0, 1, 2);
    check("midload_words", 64'(bus.words_loaded), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset", all_outputs(), 64'd0);
    $display("case reset-mid-load: outputs after async reset = %0h", all_outputs());
    run_vec(8, '{n: 16'd3, gap_max: 2, preload: 1'b0, exp_err: 1'b0, exp_words: 9'd3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader sitting directly upstream of `pipelined_mips`. It owns the CPU reset and the instruction-memory write port. After reset it zero-fills instruction memory, then accepts a byte stream of a 16-bit word count followed by big-endian 32-bit instruction words, and writes them from address 0 upward. It releases the CPU from reset once the last word is written. This replaces back-door memory initialisation, so the same program image can be delivered in simulation and on hardware.

## Interface
- `DEPTH`, 256: instruction memory depth in words.
- `ADDR_W`, 8: instruction memory word-address width; DEPTH ≤ 2^ADDR_W.
- `clk  in  1` — single clock; all state on rising edge.
- `rst  in  1` — asynchronous, active-low reset.
- `in_valid  in  1` — loader byte valid.
- `in_data  in  8` — loader byte.
- `in_ready  out  1` — loader can accept a byte; a byte transfers on an edge where `in_valid && in_ready`.
- `imem_we  out  1` — instruction memory write enable, one word per cycle.
- `imem_addr  out  ADDR_W` — word address.
- `imem_wdata  out  32` — write data.
- `cpu_rst  out  1` — active-low reset to `pipelined_mips`; 0 until load completes.
- `load_done  out  1` — image fully written, CPU released.
- `load_err  out  1` — header word count exceeds DEPTH.
- `words_loaded  out  ADDR_W+1` — count of image words written so far.

## Operation
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=0, `load_done`=0, `load_err`=0, `words_loaded`=0. State is CLEAR.
- All outputs are registered, except `in_ready`, which is decoded from state (1 only in HDR_HI, HDR_LO, DATA).
- States and transitions:
  - CLEAR: writes zero to addresses 0..DEPTH-1, one per cycle. After the write to DEPTH-1 it goes to HDR_HI.
  - HDR_HI: accepted byte → N[15:8]. Then go to HDR_LO.
  - HDR_LO: accepted byte → N[7:0].
    - N=0 → DONE.
    - N>DEPTH → ERR.
    - Otherwise → DATA.
  - DATA: bytes arrive MSB first, tracked by a 2-bit byte counter.
    - On acceptance of the 4th byte: `imem_we`=1 for one cycle, `imem_addr`=word index, `imem_wdata`={b0,b1,b2,b3}, and `words_loaded` increments.
    - After the write of word N-1 → DONE.
  - DONE: `in_ready`=0, `load_done`=1, `cpu_rst`=1. Held until reset; further input is ignored.
  - ERR: `in_ready`=0, `load_err`=1, `cpu_rst` stays 0. Held until reset.
- `in_valid` may drop at any time between bytes; partial-word bytes are retained indefinitely.
- `in_data` is ignored when no transfer occurs.
- Asserting reset in any state aborts immediately. All outputs return to reset values, including `cpu_rst`=0, which re-holds the CPU. After release, the sequence restarts at CLEAR.
- N = DEPTH is legal and fills memory completely; the word index never wraps.

## Timing
- CLEAR: on edge k after reset release (k=1..DEPTH), the registers present a write to address k-1 with `imem_wdata`=0. On edge DEPTH+1, `imem_we` drops and `in_ready` rises.
- Minimum accept rate is one byte per cycle. No bubble is inserted between words.
- Write latency is one edge: the write is presented on the cycle after the edge that accepted the 4th byte.
- Release: `cpu_rst` and `load_done` rise on the edge after the final write pulse. For N=0, they rise on the edge after the HDR_LO byte is accepted.
- `load_err` rises on the edge after the HDR_LO byte is accepted.
- Minimum load time for N words from reset release: DEPTH+1 cycles (clear), then 2+4N transfer cycles, then 1 cycle to release.

## Test plan
- Normal load, N=3: stream 00 03, 20080005, 2009000A, 01095020, one byte per cycle.
  - Writes to addr 0/1/2 with exactly those words.
  - `words_loaded`=3.
  - `cpu_rst` rises 1 cycle after the addr-2 write; `load_done`=1.
- Clear check: preload addr 200 with FFFFFFFF before reset release, then load N=2.
  - 256 zero writes occur on consecutive cycles.
  - Afterwards addr 200 reads 0 and addrs 0–1 hold the image.
- Backpressure: same N=3 image with random 0–5 cycle gaps in `in_valid`, including mid-word.
  - Identical memory contents.
  - No write issued until the 4th byte of each word is accepted.
- Empty and over-size headers:
  - 00 00 → `load_done`=1 and `cpu_rst`=1 one cycle later, no data writes.
  - 01 01 (257) → `load_err`=1, `in_ready`=0, `cpu_rst` held 0 for 100 further cycles with `in_valid` high.
- Reset mid-load: assert `rst` after 2 bytes of word 1 of a 3-word image.
  - All outputs return to reset values asynchronously.
  - After release, CLEAR reruns and a fresh full image loads correctly.
- Full memory, N=256: addr 255 is written, `words_loaded`=256, no address wrap, `cpu_rst` then rises.
